// File: rtl/fpg_timer_pkg.sv
// Shared definitions for the interval-timer tick master: slave register map,
// control-register bit positions and the master FSM state encoding.
package fpg_timer_pkg;

  typedef enum logic [2:0] {
    REG_STATUS  = 3'd0,
    REG_CONTROL = 3'd1,
    REG_PERIODL = 3'd2,
    REG_PERIODH = 3'd3,
    REG_SNAPL   = 3'd4,
    REG_SNAPH   = 3'd5
  } reg_idx_e;

  typedef enum int unsigned {
    BIT_ITO   = 0,
    BIT_CONT  = 1,
    BIT_START = 2,
    BIT_STOP  = 3
  } ctrl_bit_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_RUN,
    S_CLR,
    S_STOP,
    S_SN_WR,
    S_RD_L,
    S_RD_H,
    S_RD_E
  } state_e;

endpackage

// File: rtl/fpg_timer_tick_master.sv
// Avalon-MM host that programs the interval timer, services its IRQ as a
// fabric tick and reads back counter snapshots on request.
module fpg_timer_tick_master
  import fpg_timer_pkg::*;
#(
  parameter int unsigned TICK_W    = 32,
  parameter logic [3:0]  CTRL_RUN  = 4'h7,
  parameter logic [3:0]  CTRL_STOP = 4'h8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [31:0]       period_in,
  input  logic              snap_req,
  input  logic              timer_irq,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  output logic [TICK_W-1:0] tick_count,
  output logic              tick_pulse,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
  output logic              busy
);

  state_e      state;
  logic [15:0] period_hi;
  logic [15:0] snap_lo;

  // Bus outputs are registered: each branch drives the access belonging to
  // the state being entered, so the bus is visible during that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      period_hi      <= '0;
      snap_lo        <= '0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      tick_count     <= '0;
      tick_pulse     <= 1'b0;
      snap_value     <= '0;
      snap_valid     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      tick_pulse     <= 1'b0;
      snap_valid     <= 1'b0;
      busy           <= 1'b0;

      case (state)
        S_IDLE: begin
          if (enable) begin
            period_hi      <= period_in[31:16];
            tick_count     <= '0;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= REG_PERIODL;
            avm_writedata  <= period_in[15:0];
            busy           <= 1'b1;
            state          <= S_WR_PL;
          end
        end
        S_WR_PL: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= REG_PERIODH;
          avm_writedata  <= period_hi;
          busy           <= 1'b1;
          state          <= S_WR_PH;
        end
        S_WR_PH: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= REG_CONTROL;
          avm_writedata  <= {12'h000, CTRL_RUN};
          busy           <= 1'b1;
          state          <= S_WR_CTRL;
        end
        S_WR_CTRL: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (timer_irq) begin
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= REG_STATUS;
            tick_count     <= tick_count + 1'b1;
            tick_pulse     <= 1'b1;
            busy           <= 1'b1;
            state          <= S_CLR;
          end else if (!enable) begin
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= REG_CONTROL;
            avm_writedata  <= {12'h000, CTRL_STOP};
            busy           <= 1'b1;
            state          <= S_STOP;
          end else if (snap_req) begin
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= REG_SNAPL;
            busy           <= 1'b1;
            state          <= S_SN_WR;
          end
        end
        S_CLR: begin
          state <= S_RUN;
        end
        S_STOP: begin
          state <= S_IDLE;
        end
        S_SN_WR: begin
          avm_chipselect <= 1'b1;
          avm_address    <= REG_SNAPL;
          busy           <= 1'b1;
          state          <= S_RD_L;
        end
        S_RD_L: begin
          avm_chipselect <= 1'b1;
          avm_address    <= REG_SNAPH;
          busy           <= 1'b1;
          state          <= S_RD_H;
        end
        // Read data lags its address by one cycle: low half lands here,
        // high half one state later in RD_E.
        S_RD_H: begin
          snap_lo <= avm_readdata;
          busy    <= 1'b1;
          state   <= S_RD_E;
        end
        S_RD_E: begin
          snap_value <= {avm_readdata, snap_lo};
          snap_valid <= 1'b1;
          state      <= S_RUN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpg_timer_tick_master.md
Name: fpg_timer_tick_master

Overview:
- Avalon-MM host (initiator) that drives the 16-bit, 6-register interval-timer slave in FPGBuddy.
- Programs the period, starts the timer in continuous/IRQ mode, and services each timer IRQ by clearing the status register.
- Counts ticks and, on request, takes a counter snapshot and reads it back over two 16-bit reads.
- Lets fabric logic own a periodic tick without Nios II software involvement.

Parameters:
- TICK_W, 32, width of the tick counter output.
- CTRL_RUN, 4'h7, control word written at start (ITO|CONT|START).
- CTRL_STOP, 4'h8, control word written at stop (STOP).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset. One clock domain; reset polarity and synchronicity are fixed.
- enable  in  1  level; rising into RUN starts the timer, low stops it.
- period_in  in  32  period value (count-1), sampled when leaving IDLE.
- snap_req  in  1  one-cycle pulse requesting a snapshot; ignored unless in RUN.
- timer_irq  in  1  slave irq (level).
- avm_address  out  3  slave register index.
- avm_chipselect  out  1  bus strobe.
- avm_write_n  out  1  0 = write, 1 = read.
- avm_writedata  out  16  write data.
- avm_readdata  in  16  slave read data; registered, valid 1 cycle after the address is presented.
- tick_count  out  TICK_W  IRQs serviced since start; wraps modulo 2^TICK_W.
- tick_pulse  out  1  one-cycle pulse per serviced IRQ.
- snap_value  out  32  last snapshot {high, low}.
- snap_valid  out  1  one-cycle pulse when snap_value has been updated.
- busy  out  1  high in any state other than IDLE and RUN.

Behaviour:
- Bus idle value (IDLE, RUN, reset): chipselect=0, write_n=1, address=0, writedata=0.
- Every access lasts exactly one cycle. The slave has no waitrequest.
- Reset values: all outputs 0 except avm_write_n=1. State goes to IDLE. tick_count and snap_value are cleared.
- FSM states and per-cycle bus activity:
  - IDLE: enable=1 → latch period_in → WR_PL.
  - WR_PL: write addr 2, data = period[15:0] → WR_PH.
  - WR_PH: write addr 3, data = period[31:16] → WR_CTRL.
  - WR_CTRL: write addr 1, data = CTRL_RUN → RUN. The slave's START has priority over the force_reload stop, so no gap cycle is needed.
  - RUN, priority order: timer_irq=1 → CLR; else enable=0 → STOP; else snap_req=1 → SN_WR; else stay in RUN.
  - CLR: write addr 0, data 0. tick_count+1 and tick_pulse=1 in the same cycle. Next state is RUN; the slave irq is already low by then.
  - STOP: write addr 1, data CTRL_STOP → IDLE. tick_count holds its value until the next start, where it is cleared in WR_PL.
  - SN_WR: write addr 4 (latches the snapshot) → RD_L.
  - RD_L: read addr 4 → RD_H.
  - RD_H: read addr 5; capture avm_readdata into snap[15:0] → RD_E.
  - RD_E: bus idle; capture avm_readdata into snap[31:16]; snap_valid=1 on the next cycle (registered) → RUN.
- Snapshot latency: snap_req to snap_valid is 5 cycles.
- snap_req arriving outside RUN is dropped. The pending request is not queued.
- IRQ arriving during a snapshot sequence waits until the return to RUN. It is level-held by the slave, so it is not lost.
- enable falling mid-sequence: the sequence completes, then RUN evaluates enable and goes to STOP.
- A timeout coinciding with the CLR write is lost in the slave. This is accepted: one missed tick, no hang.
- tick_count wraps to 0 silently.
- Reset mid-operation: bus returns to idle on the next cycle. A pending snap_valid is never issued.

Decomposition:
- Shared package fpg_timer_pkg holds:
  - Register indices: STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5.
  - Control bit positions: ITO=0, CONT=1, START=2, STOP=3.
  - The FSM state enum.
- No sub-module. A single FSM with an output register stage is sufficient.

Test Plan:
- Reset → bus idle, tick_count=0, snap_valid=0, busy=0. Hold enable=0 for 10 cycles → no chipselect.
- enable=1 with period_in=0x0001_86A0 → writes on consecutive cycles: (2, 0x86A0), (3, 0x0001), (1, 0x0007); busy high for 3 cycles.
- Timer model asserts irq 3 times → a write (0, 0x0000) one cycle after each irq; tick_count=3, 3 tick_pulse.
- snap_req with model snapshot 0x1234_5678 → sequence: write 4, read 4, read 5; snap_value=0x12345678 and snap_valid exactly 5 cycles after snap_req.
- irq and snap_req in the same cycle → CLR first, then back to RUN; snap_req is dropped (no addr 4 access), tick_count+1.
- enable=0 in RUN → write (1, 0x0008), then IDLE. Separately, reset asserted during RD_H → bus idle next cycle, snap_valid never pulses.
